// File: rtl/fft_operand_select.sv
// Operand-fetch stage for the radix-2 FFT butterfly: two register-file reads plus twiddle lookup, one registered cycle.
// Optional macro TWIDDLE_CONJ_EN: negate the sine term (forward-FFT W = cos - j*sin).

module fft_rf_port #(
  parameter int D_WIDTH     = 64,
  parameter int LOG_2_WIDTH = 6,
  parameter int DATA_W      = 16
) (
  input  logic [D_WIDTH-1:0][DATA_W-1:0] regs_re,
  input  logic [D_WIDTH-1:0][DATA_W-1:0] regs_im,
  input  logic [LOG_2_WIDTH-1:0]         idx,
  output logic [DATA_W-1:0]              rd_re,
  output logic [DATA_W-1:0]              rd_im
);
  localparam logic [LOG_2_WIDTH:0] IDX_LIM = (LOG_2_WIDTH+1)'(D_WIDTH);

  // Out-of-range indices only exist when D_WIDTH is not a power of two.
  always_comb begin
    rd_re = '0;
    rd_im = '0;
    if ({1'b0, idx} < IDX_LIM) begin
      rd_re = regs_re[idx];
      rd_im = regs_im[idx];
    end
  end
endmodule

module fft_operand_select #(
  parameter int D_WIDTH     = 64,
  parameter int LOG_2_WIDTH = 6,
  parameter int DATA_W      = 16,
  parameter int TW_W        = 9
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  input  logic [D_WIDTH-1:0][DATA_W-1:0] regs_re,
  input  logic [D_WIDTH-1:0][DATA_W-1:0] regs_im,
  input  logic [LOG_2_WIDTH-1:0]         idx_a,
  input  logic [LOG_2_WIDTH-1:0]         idx_b,
  input  logic [LOG_2_WIDTH-1:0]         tw_idx,
  output logic                           out_valid,
  output logic [DATA_W-1:0]              a_re,
  output logic [DATA_W-1:0]              a_im,
  output logic [DATA_W-1:0]              b_re,
  output logic [DATA_W-1:0]              b_im,
  output logic signed [TW_W-1:0]         tw_re,
  output logic signed [TW_W-1:0]         tw_im
);
  localparam int STAGES = 1;
  localparam int NUM_PORTS = 2;

  typedef struct packed {
    logic [DATA_W-1:0]      a_re;
    logic [DATA_W-1:0]      a_im;
    logic [DATA_W-1:0]      b_re;
    logic [DATA_W-1:0]      b_im;
    logic signed [TW_W-1:0] tw_re;
    logic signed [TW_W-1:0] tw_im;
  } rsp_t;

  // First quadrant of round(255*sin(2*pi*q/64)), q = 0..16.
  function automatic logic signed [8:0] sin_q(input logic [4:0] q);
    case (q)
      5'd0:  sin_q = 9'sd0;
      5'd1:  sin_q = 9'sd25;
      5'd2:  sin_q = 9'sd50;
      5'd3:  sin_q = 9'sd74;
      5'd4:  sin_q = 9'sd98;
      5'd5:  sin_q = 9'sd120;
      5'd6:  sin_q = 9'sd142;
      5'd7:  sin_q = 9'sd162;
      5'd8:  sin_q = 9'sd180;
      5'd9:  sin_q = 9'sd197;
      5'd10: sin_q = 9'sd212;
      5'd11: sin_q = 9'sd225;
      5'd12: sin_q = 9'sd236;
      5'd13: sin_q = 9'sd244;
      5'd14: sin_q = 9'sd250;
      5'd15: sin_q = 9'sd254;
      5'd16: sin_q = 9'sd255;
      default: sin_q = 9'sd0;
    endcase
  endfunction

  // Full period from the quadrant: mirror the second quadrant, negate the second half.
  function automatic logic signed [8:0] sin_t(input logic [5:0] n);
    logic [4:0]        m;
    logic [4:0]        q;
    logic signed [8:0] mag;
    m   = n[4:0];
    q   = m[4] ? 5'(6'd32 - {1'b0, m}) : m;
    mag = sin_q(q);
    sin_t = n[5] ? -mag : mag;
  endfunction

  logic [NUM_PORTS-1:0][LOG_2_WIDTH-1:0] rd_idx;
  logic [NUM_PORTS-1:0][DATA_W-1:0]      rd_re, rd_im;

  assign rd_idx = {idx_b, idx_a};

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    fft_rf_port #(
      .D_WIDTH(D_WIDTH), .LOG_2_WIDTH(LOG_2_WIDTH), .DATA_W(DATA_W)
    ) u_port (
      .regs_re(regs_re),
      .regs_im(regs_im),
      .idx    (rd_idx[p]),
      .rd_re  (rd_re[p]),
      .rd_im  (rd_im[p])
    );
  end

  logic [5:0]        tw_a, tw_a_cos;
  logic signed [8:0] t_sin, t_cos;

  assign tw_a     = 6'(tw_idx);
  assign tw_a_cos = tw_a + 6'd16;  // cos via quarter-period shift, wraps mod 64
  assign t_sin    = sin_t(tw_a);
  assign t_cos    = sin_t(tw_a_cos);

  rsp_t rsp_d, rsp_q;

  always_comb begin
    rsp_d       = '0;
    rsp_d.a_re  = rd_re[0];
    rsp_d.a_im  = rd_im[0];
    rsp_d.b_re  = rd_re[1];
    rsp_d.b_im  = rd_im[1];
    rsp_d.tw_re = TW_W'(t_cos);
`ifdef TWIDDLE_CONJ_EN
    // Table never holds -256, so negation cannot overflow.
    rsp_d.tw_im = TW_W'(-t_sin);
`else
    rsp_d.tw_im = TW_W'(t_sin);
`endif
  end

  logic [STAGES:1] vld_q;
  logic [STAGES:0] vld_pipe;

  assign vld_pipe = {vld_q, in_valid};

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      rsp_q <= '0;
    end else begin
      vld_q <= vld_pipe[STAGES-1:0];
      rsp_q <= rsp_d;
    end
  end

  assign out_valid = vld_pipe[STAGES];
  assign a_re      = rsp_q.a_re;
  assign a_im      = rsp_q.a_im;
  assign b_re      = rsp_q.b_re;
  assign b_im      = rsp_q.b_im;
  assign tw_re     = rsp_q.tw_re;
  assign tw_im     = rsp_q.tw_im;
endmodule

// File: tb/tb_fft_operand_select.sv
// Directed bench for fft_operand_select; expectations are hand-computed twiddles and the regs pattern re=i*3, im=FFFF-i.
module tb_fft_operand_select;
  localparam int D = 64, L = 6, DW = 16, TW = 9;
`ifdef TWIDDLE_CONJ_EN
  localparam int SG = -1;
`else
  localparam int SG = 1;
`endif

  logic                    clk = 1'b0;
  logic                    rst, in_valid;
  logic [D-1:0][DW-1:0]    regs_re, regs_im;
  logic [L-1:0]            idx_a, idx_b, tw_idx;
  logic                    out_valid;
  logic [DW-1:0]           a_re, a_im, b_re, b_im;
  logic signed [TW-1:0]    tw_re, tw_im;

  fft_operand_select #(.D_WIDTH(D), .LOG_2_WIDTH(L), .DATA_W(DW), .TW_W(TW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .regs_re(regs_re), .regs_im(regs_im),
    .idx_a(idx_a), .idx_b(idx_b), .tw_idx(tw_idx),
    .out_valid(out_valid),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
    .tw_re(tw_re), .tw_im(tw_im)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_bad = 0;

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input int ia, input int ib, input int tk);
    in_valid = v;
    idx_a    = L'(ia);
    idx_b    = L'(ib);
    tw_idx   = L'(tk);
  endtask

  // tim_raw is +sin; the conjugate build flips it
  task automatic expect_out(input string tag, input bit v, input int ia, input int ib,
                            input int tre, input int tim_raw);
    chk({tag, ".vld"},  32'(out_valid), 32'(v));
    chk({tag, ".a_re"}, 32'(a_re), ia * 3);
    chk({tag, ".a_im"}, 32'(a_im), 65535 - ia);
    chk({tag, ".b_re"}, 32'(b_re), ib * 3);
    chk({tag, ".b_im"}, 32'(b_im), 65535 - ib);
    chk({tag, ".tw_re"}, 32'(tw_re), tre);
    chk({tag, ".tw_im"}, 32'(tw_im), SG * tim_raw);
  endtask

  task automatic expect_zero(input string tag);
    chk({tag, ".vld"}, 32'(out_valid), 0);
    chk({tag, ".data"}, 32'({a_re, a_im} | {b_re, b_im}), 0);
    chk({tag, ".tw"}, 32'({tw_re, tw_im}), 0);
  endtask

  int bb_ia  [8] = '{0, 63, 12, 40, 7, 33, 21, 58};
  int bb_ib  [8] = '{1, 2, 62, 40, 9, 0, 50, 17};
  int bb_tw  [8] = '{4, 8, 16, 50, 48, 0, 12, 2};
  int bb_tre [8] = '{236, 180, 0, 50, 0, 255, 98, 250};
  int bb_tim [8] = '{98, 180, 255, -250, -255, 0, 236, 50};
  bit bb_v   [8] = '{1, 0, 1, 1, 0, 1, 0, 1};

  initial begin
    for (int i = 0; i < D; i++) begin
      regs_re[i] = DW'(i * 3);
      regs_im[i] = DW'(16'hFFFF - i);
    end
    rst = 1'b1;
    drive(1, 5, 37, 8);

    // reset holds everything at zero despite valid inputs
    step(); expect_zero("rst0");
    step(); expect_zero("rst1");

    rst = 1'b0;
    drive(1, 5, 37, 0);
    step(); expect_out("mux", 1, 5, 37, 255, 0);

    drive(1, 5, 37, 4);   step(); expect_out("tw4", 1, 5, 37, 236, 98);
    drive(1, 5, 37, 8);   step(); expect_out("tw8", 1, 5, 37, 180, 180);
    drive(1, 5, 37, 16);  step(); expect_out("tw16", 1, 5, 37, 0, 255);
    drive(1, 5, 37, 50);  step(); expect_out("tw50", 1, 5, 37, 50, -250);
    drive(1, 5, 37, 48);  step(); expect_out("tw48", 1, 5, 37, 0, -255);

    drive(1, 63, 63, 1);  step(); expect_out("same63", 1, 63, 63, 254, 25);

    // back-to-back with in_valid toggling; check latency is exactly one cycle
    for (int i = 0; i < 8; i++) begin
      drive(bb_v[i], bb_ia[i], bb_ib[i], bb_tw[i]);
      #3;
      if (i > 0) expect_out($sformatf("hold%0d", i), bb_v[i-1], bb_ia[i-1], bb_ib[i-1],
                            bb_tre[i-1], bb_tim[i-1]);
      step();
      expect_out($sformatf("bb%0d", i), bb_v[i], bb_ia[i], bb_ib[i], bb_tre[i], bb_tim[i]);
    end

    // mid-stream reset drops the coinciding request
    drive(1, 1, 2, 2);  step(); expect_out("pre", 1, 1, 2, 250, 50);
    rst = 1'b1;
    drive(1, 10, 20, 8); step(); expect_zero("midrst");
    rst = 1'b0;
    drive(1, 3, 4, 4);  step(); expect_out("post", 1, 3, 4, 236, 98);
    drive(0, 3, 4, 4);  step(); expect_out("idle", 0, 3, 4, 236, 98);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
